// File: rtl/sw_btn_ctrl.sv
// Board switch/button input controller: 2-FF synchronisers, tick-sampled debounce,
// sticky W1C press/change events, CPU-readable STATUS/VALUE and a level irq.
module sw_btn_ctrl #(
  parameter int unsigned DEB_CNT = 500000,
  parameter int unsigned STABLE  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn_raw,
  input  logic [7:0]  sw_raw,
  input  logic        io_sel,
  input  logic        io_we,
  input  logic        io_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  btn,
  output logic [7:0]  sw,
  output logic        irq
);

  localparam int unsigned NB      = 12;
  localparam logic [19:0] PRE_MAX = 20'(DEB_CNT - 1);
  localparam logic [2:0]  CNT_MAX = 3'(STABLE - 1);

  logic [NB-1:0] raw_all;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [19:0]   pre_cnt;
  logic          tick;
  logic [2:0]    deb_cnt [NB];
  logic [NB-1:0] clean;
  logic [NB-1:0] clean_prev;

  logic [3:0]    btn_evt;
  logic [7:0]    sw_evt;
  logic          irq_en;

  logic          wr_status;
  logic          rd_strobe;
  logic [3:0]    btn_set;
  logic [3:0]    btn_clr;
  logic [7:0]    sw_set;
  logic [7:0]    sw_clr;
  logic [31:0]   rd_word;

  // Buttons occupy the upper nibble of the combined vector, switches the low byte.
  always_comb begin
    raw_all = {btn_raw, sw_raw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  always_comb begin
    tick = (pre_cnt == PRE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 20'd1;
    end
  end

  // A level is accepted only after STABLE consecutive disagreeing ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB; i++) begin
        deb_cnt[i] <= '0;
      end
      clean <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == clean[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_MAX) begin
          clean[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 3'd1;
        end
      end
    end
  end

  always_comb begin
    btn = clean[11:8];
    sw  = clean[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_prev <= '0;
    end else begin
      clean_prev <= clean;
    end
  end

  always_comb begin
    wr_status = io_sel & io_we & ~io_addr;
    rd_strobe = io_sel & ~io_we;
    btn_set   = clean[11:8] & ~clean_prev[11:8];
    sw_set    = clean[7:0] ^ clean_prev[7:0];
    btn_clr   = '0;
    sw_clr    = '0;
    if (wr_status) begin
      btn_clr = data_in[3:0];
      sw_clr  = data_in[11:4];
    end
  end

  // Set is OR-ed in after the clear so a colliding event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_evt <= '0;
      sw_evt  <= '0;
      irq_en  <= 1'b0;
    end else begin
      btn_evt <= (btn_evt & ~btn_clr) | btn_set;
      sw_evt  <= (sw_evt & ~sw_clr) | sw_set;
      if (wr_status) begin
        irq_en <= data_in[12];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (io_addr) begin
      rd_word = {20'h0, clean[11:8], clean[7:0]};
    end else begin
      rd_word = {19'h0, irq_en, sw_evt, btn_evt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_strobe) begin
      data_out <= rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & ((|btn_evt) | (|sw_evt));
    end
  end

endmodule

// File: tb/tb_sw_btn_ctrl.sv
// Self-checking bench for sw_btn_ctrl with a short prescaler (DEB_CNT=4, STABLE=3).
module tb_sw_btn_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned STB = 3;
  localparam int unsigned SETTLE = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn_raw = '0;
  logic [7:0]  sw_raw = '0;
  logic        io_sel = 1'b0;
  logic        io_we = 1'b0;
  logic        io_addr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0]  btn;
  logic [7:0]  sw;
  logic        irq;

  always #5 clk = ~clk;

  sw_btn_ctrl #(.DEB_CNT(DEB), .STABLE(STB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .io_sel   (io_sel),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .data_in  (data_in),
    .data_out (data_out),
    .btn      (btn),
    .sw       (sw),
    .irq      (irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [3:0] b_in;
    logic [7:0] s_in;
    logic [3:0] b_exp;
    logic [7:0] s_exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the read is captured on the next posedge.
  task automatic bus_read(input logic addr, input logic [31:0] exp, input string name);
    io_sel  = 1'b1;
    io_we   = 1'b0;
    io_addr = addr;
    data_in = '0;
    exp_q.push_back(exp);
    @(negedge clk);
    io_sel = 1'b0;
    check(name, data_out, exp_q.pop_front());
  endtask

  task automatic bus_write(input logic addr, input logic [31:0] data);
    io_sel  = 1'b1;
    io_we   = 1'b1;
    io_addr = addr;
    data_in = data;
    @(negedge clk);
    io_sel  = 1'b0;
    io_we   = 1'b0;
    data_in = '0;
  endtask

  task automatic wait_btn(input int idx, input int budget, output int cycles);
    cycles = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (btn[idx]) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [3:0] m_btn_evt;
    logic [7:0] m_sw_evt;
    logic [3:0] prev_b;
    logic [7:0] prev_s;

    vecs[0] = '{b_in: 4'h0, s_in: 8'h3C, b_exp: 4'h0, s_exp: 8'h3C};
    vecs[1] = '{b_in: 4'h9, s_in: 8'h3C, b_exp: 4'h9, s_exp: 8'h3C};
    vecs[2] = '{b_in: 4'h9, s_in: 8'hC3, b_exp: 4'h9, s_exp: 8'hC3};
    vecs[3] = '{b_in: 4'h0, s_in: 8'hFF, b_exp: 4'h0, s_exp: 8'hFF};
    vecs[4] = '{b_in: 4'h6, s_in: 8'h00, b_exp: 4'h6, s_exp: 8'h00};
    vecs[5] = '{b_in: 4'h0, s_in: 8'h00, b_exp: 4'h0, s_exp: 8'h00};

    // Reset with random pads
    btn_raw = 4'($urandom);
    sw_raw  = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_btn", 32'(btn), 32'h0);
    check("rst_sw", 32'(sw), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_data_out", data_out, 32'h0);
    rst_n = 1'b1;
    bus_read(1'b0, 32'h0, "rst_status");
    btn_raw = '0;
    sw_raw  = '0;
    settle();

    // Clean press on btn[0], event lands one cycle after btn
    btn_raw[0] = 1'b1;
    wait_btn(0, 16, lat);
    check("press_latency_in_range", 32'((lat >= 10) && (lat <= 14)), 32'h1);
    bus_read(1'b0, 32'h0, "press_evt_not_yet");
    bus_read(1'b0, 32'h1, "press_status");
    btn_raw[0] = 1'b0;
    settle();
    check("release_btn0", 32'(btn), 32'h0);
    bus_read(1'b0, 32'h1, "release_no_new_evt");
    bus_write(1'b0, 32'h1);
    bus_read(1'b0, 32'h0, "press_cleared");

    // Bounce on btn[1]: one tick high, one tick low, five times
    seen = 1'b0;
    for (int r = 0; r < 5; r++) begin
      btn_raw[1] = 1'b1;
      repeat (DEB) begin
        @(negedge clk);
        seen |= btn[1];
      end
      btn_raw[1] = 1'b0;
      repeat (DEB) begin
        @(negedge clk);
        seen |= btn[1];
      end
    end
    repeat (SETTLE) begin
      @(negedge clk);
      seen |= btn[1];
    end
    check("bounce_btn1_never_high", 32'(seen), 32'h0);
    bus_read(1'b0, 32'h0, "bounce_no_evt");

    // Switch change, W1C, change back
    sw_raw = 8'hA5;
    settle();
    check("sw_a5", 32'(sw), 32'hA5);
    bus_read(1'b1, 32'h0000_00A5, "value_a5");
    bus_read(1'b0, 32'h0000_0A50, "status_a5");
    bus_write(1'b1, 32'hFFFF_FFFF);
    bus_read(1'b1, 32'h0000_00A5, "value_write_ignored");
    bus_write(1'b0, 32'h0000_0A50);
    bus_read(1'b0, 32'h0, "status_cleared");
    sw_raw = 8'h00;
    settle();
    bus_read(1'b0, 32'h0000_0A50, "status_back_to_0");
    bus_write(1'b0, 32'h0000_0A50);
    bus_read(1'b0, 32'h0, "status_cleared2");

    // Table vectors with event model
    m_btn_evt = '0;
    m_sw_evt  = '0;
    prev_b    = '0;
    prev_s    = '0;
    for (int v = 0; v < 6; v++) begin
      btn_raw = vecs[v].b_in;
      sw_raw  = vecs[v].s_in;
      settle();
      m_btn_evt |= vecs[v].b_exp & ~prev_b;
      m_sw_evt  |= vecs[v].s_exp ^ prev_s;
      prev_b = vecs[v].b_exp;
      prev_s = vecs[v].s_exp;
      check($sformatf("vec%0d_btn", v), 32'(btn), 32'(vecs[v].b_exp));
      check($sformatf("vec%0d_sw", v), 32'(sw), 32'(vecs[v].s_exp));
      bus_read(1'b1, {20'h0, vecs[v].b_exp, vecs[v].s_exp}, $sformatf("vec%0d_value", v));
      bus_read(1'b0, {19'h0, 1'b0, m_sw_evt, m_btn_evt}, $sformatf("vec%0d_status", v));
    end
    bus_write(1'b0, 32'h0000_0FFF);
    bus_read(1'b0, 32'h0, "table_cleared");

    // Interrupt enable, assert and clear timing
    bus_write(1'b0, 32'h0000_1000);
    @(negedge clk);
    check("irq_en_no_evt", 32'(irq), 32'h0);
    bus_read(1'b0, 32'h0000_1000, "irq_en_status");
    btn_raw[2] = 1'b1;
    wait_btn(2, 16, lat);
    check("irq_btn2_seen", 32'(lat != 0), 32'h1);
    check("irq_at_btn", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_at_evt", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_after_evt", 32'(irq), 32'h1);
    bus_read(1'b0, 32'h0000_1004, "irq_status");
    bus_write(1'b0, 32'h0000_1004);
    check("irq_hold_at_clear", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_drop_after_clear", 32'(irq), 32'h0);
    btn_raw[2] = 1'b0;
    settle();
    bus_read(1'b0, 32'h0000_1000, "irq_release_status");

    // Clear of bit 3 colliding with its set
    btn_raw[3] = 1'b1;
    wait_btn(3, 16, lat);
    check("coll_btn3_seen", 32'(lat != 0), 32'h1);
    bus_write(1'b0, 32'h0000_1008);
    @(negedge clk);
    check("coll_irq", 32'(irq), 32'h1);
    bus_read(1'b0, 32'h0000_1008, "coll_status");
    check("coll_irq_still", 32'(irq), 32'h1);

    // Reset mid-count and mid-access
    sw_raw = 8'h0F;
    repeat (6) @(negedge clk);
    io_sel  = 1'b1;
    io_we   = 1'b0;
    io_addr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_btn", 32'(btn), 32'h0);
    check("midrst_sw", 32'(sw), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_data_out", data_out, 32'h0);
    io_sel  = 1'b0;
    btn_raw = '0;
    sw_raw  = '0;
    @(negedge clk);
    check("midrst_data_out_held", data_out, 32'h0);
    rst_n = 1'b1;
    bus_read(1'b0, 32'h0, "midrst_status");
    bus_read(1'b1, 32'h0, "midrst_value");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
